serial_parity_frame_ctrl: RTL and testbench

//  Sequencer for the serial even-parity check. Frames a 1-bit-per-clock serial line

---
 rtl/serial_parity_frame_ctrl.sv | 111 +++++++++++
 tb/tb_serial_parity_frame_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/serial_parity_frame_ctrl.sv
// Serial even-parity frame receiver: start / data / parity / stop framing with a
// one-entry valid/ready output buffer, error flags and a saturating error counter.
module serial_parity_frame_ctrl #(
    parameter int DATA_BITS = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_in,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_parity_err,
    output logic                 out_frame_err,
    output logic                 overrun,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 busy
);

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t               state;
    state_t               next_state;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 acc;
    logic [DATA_BITS-1:0] data_sr;
    logic [DATA_BITS:0]   shift_in;
    logic                 commit;
    logic                 frame_bad;
    logic                 can_load;

    // A frame completes on the edge that samples the stop bit.
    assign commit    = (state == STOP);
    assign frame_bad = acc | ~serial_in;
    assign can_load  = !out_valid || out_ready;
    assign shift_in  = {serial_in, data_sr};
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!serial_in) next_state = DATA;
            DATA:    if (bit_cnt == LAST_BIT) next_state = PARITY;
            PARITY:  next_state = STOP;
            STOP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Data arrives LSB first, so shifting right leaves the first bit in bit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt <= '0;
            acc     <= 1'b0;
            data_sr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!serial_in) begin
                        bit_cnt <= '0;
                        acc     <= 1'b0;
                    end
                end
                DATA: begin
                    data_sr <= shift_in[DATA_BITS:1];
                    acc     <= acc ^ serial_in;
                    bit_cnt <= bit_cnt + 1'b1;
                end
                PARITY:  acc <= acc ^ serial_in;
                default: ;
            endcase
        end
    end

    // A commit into a draining buffer replaces the word; into a full one it is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_parity_err <= 1'b0;
            out_frame_err  <= 1'b0;
            overrun        <= 1'b0;
            err_count      <= '0;
        end else begin
            overrun <= 1'b0;
            if (commit) begin
                if (frame_bad && (err_count != '1))
                    err_count <= err_count + 1'b1;
                if (can_load) begin
                    out_data       <= data_sr;
                    out_parity_err <= acc;
                    out_frame_err  <= ~serial_in;
                    out_valid      <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_parity_frame_ctrl.sv
// Randomized bench for serial_parity_frame_ctrl: frames are built as whole words and
// the expected buffer contents are tracked per frame by a transaction-level model.
module tb_serial_parity_frame_ctrl;

    localparam int DB = 8;
    localparam int EW = 3;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          serial_in;
    logic          out_ready;
    logic          out_valid;
    logic [DB-1:0] out_data;
    logic          out_parity_err;
    logic          out_frame_err;
    logic          overrun;
    logic [EW-1:0] err_count;
    logic          busy;

    int checks = 0;
    int failures = 0;

    bit          m_valid;
    bit [DB-1:0] m_data;
    bit          m_perr;
    bit          m_ferr;
    bit          m_ovr;
    int          m_errs;

    serial_parity_frame_ctrl #(.DATA_BITS(DB), .ERR_CNT_W(EW)) dut (
        .clk(clk),
        .reset(reset),
        .serial_in(serial_in),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_parity_err(out_parity_err),
        .out_frame_err(out_frame_err),
        .overrun(overrun),
        .err_count(err_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic applyStimulus(input bit rst, input bit sin, input bit rdy, input bit done,
                                 input bit [DB-1:0] d, input bit perr, input bit ferr, input bit exp_busy);
        @(negedge clk);
        reset     = rst;
        serial_in = sin;
        out_ready = rdy;
        m_ovr = 1'b0;
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_perr  = 1'b0;
            m_ferr  = 1'b0;
            m_errs  = 0;
        end else if (done) begin
            if (perr || ferr) m_errs++;
            if (!m_valid || rdy) begin
                m_valid = 1'b1;
                m_data  = d;
                m_perr  = perr;
                m_ferr  = ferr;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
        checkOutput("out_data", 32'(out_data), 32'(m_data));
        checkOutput("out_parity_err", 32'(out_parity_err), 32'(m_perr));
        checkOutput("out_frame_err", 32'(out_frame_err), 32'(m_ferr));
        checkOutput("overrun", 32'(overrun), 32'(m_ovr));
        checkOutput("err_count", 32'(err_count), 32'((m_errs > ERR_MAX) ? ERR_MAX : m_errs));
        checkOutput("busy", 32'(busy), 32'(exp_busy && !rst));
    endtask

    function automatic bit pickReady(input int mode, input int pos);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return 1'($urandom % 2);
            default: return (pos == DB + 2);
        endcase
    endfunction

    // mode: 0 never ready, 1 always ready, 2 random, 3 ready only on the stop-bit edge.
    task automatic sendFrame(input bit [DB-1:0] d, input bit par, input bit stp,
                             input int mode, input int abort_at);
        bit [DB+2:0] bits;
        bit          pe;
        bits = {stp, par, d, 1'b0};
        pe   = (($countones(d) + int'(par)) % 2) == 1;
        for (int i = 0; i < DB + 3; i++) begin
            if (i == abort_at) begin
                applyStimulus(1'b1, 1'b1, pickReady(mode, i), 1'b0, d, 1'b0, 1'b0, 1'b0);
                return;
            end
            applyStimulus(1'b0, bits[i], pickReady(mode, i), (i == DB + 2), d, pe, !stp, (i < DB + 2));
        end
    endtask

    task automatic idleCycles(input int n, input int mode);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b1, pickReady(mode, 0), 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        serial_in = 1'b1;
        out_ready = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

        sendFrame(8'hA5, 1'b0, 1'b1, 1, -1);
        idleCycles(2, 1);
        sendFrame(8'h07, 1'b0, 1'b1, 1, -1);
        sendFrame(8'h07, 1'b1, 1'b1, 1, -1);
        sendFrame(8'h3C, 1'b0, 1'b0, 1, -1);
        idleCycles(1, 1);
        sendFrame(8'h11, 1'b0, 1'b1, 0, -1);
        sendFrame(8'h22, 1'b0, 1'b1, 0, -1);
        idleCycles(2, 1);
        sendFrame(8'h33, 1'b0, 1'b1, 0, -1);
        sendFrame(8'h5A, 1'b0, 1'b1, 3, -1);
        idleCycles(2, 1);
        sendFrame(8'h99, 1'b0, 1'b1, 1, 4);
        sendFrame(8'h81, 1'b0, 1'b1, 1, -1);
        idleCycles(1, 1);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < ERR_MAX + 3; k++)
            sendFrame(8'h01, 1'b0, 1'b1, 1, -1);

        for (int k = 0; k < 400; k++) begin
            bit [DB-1:0] d;
            bit          par;
            bit          stp;
            int          abort_at;
            d        = DB'($urandom);
            par      = (^d) ^ (($urandom % 4) == 0);
            stp      = ($urandom % 8) != 0;
            abort_at = (($urandom % 25) == 0) ? int'($urandom_range(1, DB + 1)) : -1;
            sendFrame(d, par, stp, int'($urandom % 4), abort_at);
            idleCycles(int'($urandom % 3), 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
